// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS control FSM.
// Opcodes, functs, state codes and datapath select encodings.
package mc_pkg;

    // Register index written by jal
    localparam logic [4:0] RA_REG = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MA    = 3'd3,
        S_WB    = 3'd4,
        S_BR    = 3'd5
    } state_e;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;
    localparam logic [1:0] NPC_REG = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_PASB = 3'b100;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HIGH = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [1:0] GPR_RD = 2'b00;
    localparam logic [1:0] GPR_RT = 2'b01;
    localparam logic [1:0] GPR_RA = 2'b10;

    // Instruction-class flags; exactly one is set for any Op/Funct
    typedef struct packed {
        logic is_rtype;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_j;
        logic is_jal;
        logic is_jr;
        logic is_itype_alu;
        logic illegal;
    } dec_t;

    // ALU function used in EXE for the arithmetic/memory classes
    function automatic logic [2:0] alu_op_f(input logic [5:0] op,
                                            input logic [5:0] funct);
        logic [2:0] r;
        r = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUBU: r = ALU_SUB;
                FN_SLT:  r = ALU_SLT;
                default: r = ALU_ADD;
            endcase
        end else begin
            case (op)
                OP_ORI:  r = ALU_OR;
                OP_LUI:  r = ALU_PASB;
                default: r = ALU_ADD;
            endcase
        end
        return r;
    endfunction

    // Immediate extender mode used in EXE; R-type leaves it at zero
    function automatic logic [1:0] ext_op_f(input logic [5:0] op);
        logic [1:0] r;
        case (op)
            OP_LUI:   r = EXT_HIGH;
            OP_ADDIU: r = EXT_SIGN;
            OP_LW:    r = EXT_SIGN;
            OP_SW:    r = EXT_SIGN;
            default:  r = EXT_ZERO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational classifier from Op/Funct to one-hot
// instruction-class flags; illegal is set when no class matches.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    logic rt;

    // Classify the instruction currently held in IR
    always_comb begin
        dec_o = '0;
        rt = (op_i == OP_RTYPE);
        dec_o.is_rtype = rt && (funct_i == FN_ADDU ||
                                funct_i == FN_SUBU ||
                                funct_i == FN_SLT);
        dec_o.is_jr = rt && (funct_i == FN_JR);
        dec_o.is_lw = (op_i == OP_LW);
        dec_o.is_sw = (op_i == OP_SW);
        dec_o.is_beq = (op_i == OP_BEQ);
        dec_o.is_j = (op_i == OP_J);
        dec_o.is_jal = (op_i == OP_JAL);
        dec_o.is_itype_alu = (op_i == OP_ORI) ||
                             (op_i == OP_ADDIU) ||
                             (op_i == OP_LUI);
        dec_o.illegal = ~|{dec_o.is_rtype, dec_o.is_jr,
                           dec_o.is_lw, dec_o.is_sw,
                           dec_o.is_beq, dec_o.is_j,
                           dec_o.is_jal, dec_o.is_itype_alu};
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DCD/EXE/MA/WB/BR).
// Optional retired-instruction counter: MC_CTRL_INSTR_CNT_EN.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    output logic        PCWrite,
    output logic [1:0]  NPCOp,
    output logic        IRWrite,
    output logic        RFWrite,
    output logic        DMWrite,
    output logic [1:0]  EXTOp,
    output logic        ALUSrc,
    output logic [2:0]  ALUOp,
    output logic [1:0]  WDSel,
    output logic [1:0]  GPRSel,
    output logic [31:0] instr_cnt
);

    state_e state_q, state_d;
    dec_t   dec;
    logic   pcw_d, irw_d, rfw_d, dmw_d;

    mc_decode u_dec (
        .op_i    (Op),
        .funct_i (Funct),
        .dec_o   (dec)
    );

    // Next state and datapath controls from the current phase
    always_comb begin
        state_d = S_FETCH;
        pcw_d   = 1'b0;
        irw_d   = 1'b0;
        rfw_d   = 1'b0;
        dmw_d   = 1'b0;
        NPCOp   = NPC_PC4;
        EXTOp   = EXT_ZERO;
        ALUSrc  = 1'b0;
        ALUOp   = ALU_ADD;
        WDSel   = WD_ALU;
        GPRSel  = GPR_RD;
        unique case (state_q)
            S_FETCH: begin
                pcw_d   = 1'b1;
                irw_d   = 1'b1;
                state_d = S_DCD;
            end
            S_DCD: begin
                unique case (1'b1)
                    dec.is_j: begin
                        pcw_d = 1'b1;
                        NPCOp = NPC_JMP;
                    end
                    dec.is_jal: begin
                        pcw_d  = 1'b1;
                        NPCOp  = NPC_JMP;
                        rfw_d  = 1'b1;
                        GPRSel = GPR_RA;
                        WDSel  = WD_PC;
                    end
                    dec.is_jr: begin
                        pcw_d = 1'b1;
                        NPCOp = NPC_REG;
                    end
                    dec.is_beq:       state_d = S_BR;
                    dec.is_lw:        state_d = S_EXE;
                    dec.is_sw:        state_d = S_EXE;
                    dec.is_rtype:     state_d = S_EXE;
                    dec.is_itype_alu: state_d = S_EXE;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_EXE: begin
                ALUSrc  = ~dec.is_rtype;
                ALUOp   = alu_op_f(Op, Funct);
                EXTOp   = ext_op_f(Op);
                state_d = (dec.is_lw || dec.is_sw) ? S_MA : S_WB;
            end
            S_MA: begin
                ALUSrc  = 1'b1;
                ALUOp   = ALU_ADD;
                EXTOp   = EXT_SIGN;
                dmw_d   = dec.is_sw;
                state_d = dec.is_lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                rfw_d = 1'b1;
                if (dec.is_lw) begin
                    WDSel  = WD_MEM;
                    GPRSel = GPR_RT;
                end else if (dec.is_rtype) begin
                    WDSel  = WD_ALU;
                    GPRSel = GPR_RD;
                end else begin
                    WDSel  = WD_ALU;
                    GPRSel = GPR_RT;
                end
                state_d = S_FETCH;
            end
            S_BR: begin
                ALUOp   = ALU_SUB;
                ALUSrc  = 1'b0;
                NPCOp   = NPC_BR;
                pcw_d   = Zero;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign PCWrite = rst & pcw_d;
    assign IRWrite = rst & irw_d;
    assign RFWrite = rst & rfw_d;
    assign DMWrite = rst & dmw_d;

    // Phase register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

`ifdef MC_CTRL_INSTR_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Count each return to FETCH from a later phase
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == S_FETCH && state_q != S_FETCH)
            cnt_d = cnt_q + 32'd1;
    end

    // Retired-instruction counter register
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= 32'd0;
        else      cnt_q <= cnt_d;
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl with a per-instruction
// cycle-script reference model and randomized instruction mix.
module tb_mc_ctrl;
    import mc_pkg::*;

`ifdef MC_CTRL_INSTR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        pcw;
        logic [1:0]  npc;
        logic        irw;
        logic        rfw;
        logic        dmw;
        logic [1:0]  ext;
        logic        src;
        logic [2:0]  alu;
        logic [1:0]  wd;
        logic [1:0]  gpr;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  Op, Funct;
    logic        Zero;
    logic        PCWrite, IRWrite, RFWrite, DMWrite, ALUSrc;
    logic [1:0]  NPCOp, EXTOp, WDSel, GPRSel;
    logic [2:0]  ALUOp;
    logic [31:0] instr_cnt;

    mc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .Op        (Op),
        .Funct     (Funct),
        .Zero      (Zero),
        .PCWrite   (PCWrite),
        .NPCOp     (NPCOp),
        .IRWrite   (IRWrite),
        .RFWrite   (RFWrite),
        .DMWrite   (DMWrite),
        .EXTOp     (EXTOp),
        .ALUSrc    (ALUSrc),
        .ALUOp     (ALUOp),
        .WDSel     (WDSel),
        .GPRSel    (GPRSel),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    exp_t  q[$];
    bit    full_q[$];
    string nm_q[$];
    exp_t  plan[$];
    int    total = 0;
    int    bad = 0;
    int    mcnt = 0;

    function automatic string mnem(input logic [5:0] op,
                                   input logic [5:0] fn);
        if (op == 6'd0) begin
            if (fn == 6'b100001) return "addu";
            if (fn == 6'b100011) return "subu";
            if (fn == 6'b101010) return "slt";
            if (fn == 6'b001000) return "jr";
            return "ill";
        end
        if (op == 6'b001101) return "ori";
        if (op == 6'b001001) return "addiu";
        if (op == 6'b001111) return "lui";
        if (op == 6'b100011) return "lw";
        if (op == 6'b101011) return "sw";
        if (op == 6'b000100) return "beq";
        if (op == 6'b000010) return "j";
        if (op == 6'b000011) return "jal";
        return "ill";
    endfunction

    // Expected per-cycle control script for one instruction
    task automatic build(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, output string m);
        exp_t e;
        bit rtype;
        m = mnem(op, fn);
        rtype = (m == "addu" || m == "subu" || m == "slt");
        plan.delete();
        e = '0; e.pcw = 1; e.irw = 1; plan.push_back(e);
        e = '0;
        if (m == "j") begin
            e.pcw = 1; e.npc = 2'd2; plan.push_back(e);
        end else if (m == "jal") begin
            e.pcw = 1; e.npc = 2'd2; e.rfw = 1;
            e.gpr = 2'd2; e.wd = 2'd2; plan.push_back(e);
        end else if (m == "jr") begin
            e.pcw = 1; e.npc = 2'd3; plan.push_back(e);
        end else if (m == "ill") begin
            plan.push_back(e);
        end else if (m == "beq") begin
            plan.push_back(e);
            e = '0; e.alu = 3'd1; e.npc = 2'd1; e.pcw = z;
            plan.push_back(e);
        end else begin
            plan.push_back(e);
            e = '0;
            e.src = !rtype;
            e.alu = (m == "subu") ? 3'd1 : (m == "ori") ? 3'd2 :
                    (m == "slt") ? 3'd3 : (m == "lui") ? 3'd4 : 3'd0;
            e.ext = (m == "lui") ? 2'd2 :
                    (m == "addiu" || m == "lw" || m == "sw") ? 2'd1 : 2'd0;
            plan.push_back(e);
            if (m == "lw" || m == "sw") begin
                e = '0; e.src = 1; e.ext = 2'd1; e.dmw = (m == "sw");
                plan.push_back(e);
            end
            if (m != "sw") begin
                e = '0; e.rfw = 1;
                e.wd = (m == "lw") ? 2'd1 : 2'd0;
                e.gpr = rtype ? 2'd0 : 2'd1;
                plan.push_back(e);
            end
        end
        foreach (plan[i]) plan[i].cnt = CNT_EN ? mcnt : 0;
    endtask

    task automatic push_plan(input string m, input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back(plan[i]);
            full_q.push_back(1'b1);
            nm_q.push_back($sformatf("%s_c%0d", m, i));
        end
    endtask

    // Caller is at posedge+1 with the DUT in FETCH
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic z);
        string m;
        int n;
        Op = op; Funct = fn; Zero = z;
        build(op, fn, z, m);
        n = plan.size();
        push_plan(m, n);
        repeat (n) @(posedge clk);
        #1;
        mcnt++;
    endtask

    task automatic do_reset();
        exp_t e;
        e = '0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            q.push_back(e);
            full_q.push_back(1'b0);
            nm_q.push_back($sformatf("reset_c%0d", i));
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        mcnt = 0;
    endtask

    task automatic abort_addu();
        string m;
        Op = 6'd0; Funct = 6'b100001; Zero = 1'b0;
        build(Op, Funct, Zero, m);
        push_plan("abort_addu", 2);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
    endtask

    exp_t act, want;
    bit   full;
    string nm;
    bit   ok;

    // Monitor: compare every presented cycle against the scoreboard
    always @(negedge clk) begin
        if (q.size() > 0) begin
            want = q.pop_front();
            full = full_q.pop_front();
            nm = nm_q.pop_front();
            act.pcw = PCWrite; act.npc = NPCOp; act.irw = IRWrite;
            act.rfw = RFWrite; act.dmw = DMWrite; act.ext = EXTOp;
            act.src = ALUSrc; act.alu = ALUOp; act.wd = WDSel;
            act.gpr = GPRSel; act.cnt = instr_cnt;
            total++;
            if (full) ok = (act === want);
            else ok = ({act.pcw, act.irw, act.rfw, act.dmw} === 4'b0);
            if (!ok) begin
                bad++;
                $display("FAIL %s: got %h want %h", nm, act, want);
            end
        end
    end

    logic [5:0] tops[12];
    logic [5:0] tfns[12];

    initial begin
        rst = 1'b0; Op = '0; Funct = '0; Zero = 1'b0;
        tops = '{6'd0, 6'd0, 6'd0, 6'd0, 6'b001101, 6'b001001,
                 6'b001111, 6'b100011, 6'b101011, 6'b000100,
                 6'b000010, 6'b000011};
        tfns = '{6'b100001, 6'b100011, 6'b101010, 6'b001000,
                 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        @(posedge clk);
        #1;
        do_reset();
        issue(6'b100011, 6'($urandom), 1'b0);
        issue(6'b000100, 6'($urandom), 1'b1);
        issue(6'b000100, 6'($urandom), 1'b0);
        issue(6'b000011, 6'($urandom), 1'b1);
        issue(6'b111111, 6'($urandom), 1'b0);
        abort_addu();
        issue(6'b101011, 6'($urandom), 1'b0);
        issue(6'b001101, 6'($urandom), 1'b0);
        issue(6'd0, 6'b100011, 1'b1);
        for (int k = 0; k < 300; k++) begin
            int idx;
            logic [5:0] op, fn;
            idx = $urandom_range(0, 13);
            if (idx >= 12) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = tops[idx];
                fn = (op == 6'd0) ? tfns[idx] : 6'($urandom);
            end
            if ($urandom_range(0, 39) == 0) abort_addu();
            else issue(op, fn, 1'($urandom));
        end
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle MIPS control FSM. It drives the PC register's write enable and its next-PC select, plus every other datapath write enable and mux select.
- Sequences each instruction through FETCH/DCD/EXE/MA/WB/BR phases.
- Decodes opcode/funct from the IR output and the ALU zero flag.
- Sits beside the datapath; owns PCWrite and IRWrite.

Parameters:
- RA_REG, 5'd31, register index written by jal.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, reset, synchronous, active-low.
- Op, input, 6, IR[31:26].
- Funct, input, 6, IR[5:0].
- Zero, input, 1, ALU equality flag.
- PCWrite, output, 1, PC register load enable.
- NPCOp, output, 2, next-PC select: 00 PC+4, 01 branch, 10 j/jal target, 11 register (jr).
- IRWrite, output, 1, IR load enable.
- RFWrite, output, 1, register file write enable.
- DMWrite, output, 1, data memory write enable.
- EXTOp, output, 2, immediate extender mode: 00 zero, 01 sign, 10 shift-to-high (lui).
- ALUSrc, output, 1, ALU B operand: 0 register, 1 immediate.
- ALUOp, output, 3, ALU function: 000 add, 001 sub, 010 or, 011 slt, 100 pass-B.
- WDSel, output, 2, register write data: 00 ALU result, 01 memory data, 10 PC (link).
- GPRSel, output, 2, register destination: 00 rd, 01 rt, 10 RA_REG.
- instr_cnt, output, 32, count of retired instructions (see Optional Feature).

Behaviour:
- Supported instructions:
  - R-type (Op=000000): addu (Funct 100001), subu (100011), slt (101010), jr (001000).
  - I-type and jumps: ori 001101, addiu 001001, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- State register, 3 bits: FETCH=0, DCD=1, EXE=2, MA=3, WB=4, BR=5. Codes 6 and 7 are illegal and recover to FETCH on the next edge.
- Reset: on any rising edge with rst=0, state <= FETCH and instr_cnt <= 0.
  - While rst=0, all write enables (PCWrite, IRWrite, RFWrite, DMWrite) are forced to 0 combinationally.
  - Reset mid-instruction aborts it with no further writes.
- Outputs are combinational functions of the registered state, Op, Funct and Zero. Op/Funct are stable from DCD onward because IR only loads in FETCH.
- FETCH: PCWrite=1, NPCOp=00, IRWrite=1. Next state DCD.
- DCD:
  - j: PCWrite=1, NPCOp=10. Next FETCH.
  - jal: as j, plus RFWrite=1, GPRSel=10, WDSel=10. Next FETCH.
  - jr: PCWrite=1, NPCOp=11. Next FETCH.
  - beq: next BR.
  - Other legal instructions: next EXE.
  - Illegal Op/Funct: no writes, next FETCH (treated as nop).
- EXE:
  - ALUSrc=0 for R-type, 1 otherwise.
  - ALUOp: addu, addiu, lw and sw use add; subu uses sub; ori uses or; slt uses slt; lui uses pass-B.
  - EXTOp: ori uses zero-extend; addiu, lw and sw use sign-extend; lui uses shift-to-high.
  - Next MA for lw/sw, WB for all others.
- MA: address path held as in EXE.
  - sw: DMWrite=1, next FETCH.
  - lw: next WB.
- WB: RFWrite=1.
  - lw: WDSel=01, GPRSel=01.
  - R-type: WDSel=00, GPRSel=00.
  - I-type ALU: WDSel=00, GPRSel=01.
  - Next FETCH.
- BR: ALUOp=sub, ALUSrc=0, NPCOp=01, PCWrite=Zero. Next FETCH.
- Cycles per instruction:
  - j/jal/jr/illegal: 2.
  - beq: 3.
  - R-type/ori/addiu/lui/sw: 4.
  - lw: 5.
- Defaults in every state: all enables 0, all selects 0.
- At most one PCWrite per instruction after FETCH's own; never in EXE, MA or WB.

Optional Feature:
- Macro: MC_CTRL_INSTR_CNT_EN.
- Defined: instr_cnt increments by 1 on the clock edge that leaves the final state of each instruction (transition into FETCH from a non-FETCH state).
  - Wraps 0xFFFFFFFF -> 0.
  - Reset clears it.
- Undefined: instr_cnt is tied to 32'h0 and no counter flops are generated. The port list is unchanged.

Decomposition:
- Shared package mc_pkg holds:
  - Opcode and funct constants.
  - State encodings.
  - NPCOp, ALUOp, EXTOp, WDSel and GPRSel encodings, used by datapath and bench alike.
- Natural sub-module: mc_decode, a combinational classifier mapping Op/Funct to instruction-class flags (is_rtype, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, is_itype_alu, illegal). The FSM consumes these flags.

Test Plan:
- Reset then run: rst=0 for 2 edges then rst=1 -> no write enable high during reset; first cycle after release is FETCH with PCWrite=1, IRWrite=1, NPCOp=00.
- lw (Op=100011) -> states F,D,E,MA,WB over 5 cycles; in WB, RFWrite=1, WDSel=01, GPRSel=01; with MC_CTRL_INSTR_CNT_EN defined, instr_cnt goes 0 -> 1.
- beq with Zero=1, then again with Zero=0 -> BR cycle shows PCWrite=1, NPCOp=01 in the first case and PCWrite=0 in the second; 3 cycles each.
- jal (Op=000011) -> in DCD, PCWrite=1, NPCOp=10, RFWrite=1, GPRSel=10, WDSel=10; FETCH on the next cycle.
- Illegal Op=111111, then rst=0 asserted during the EXE cycle of an addu -> illegal instruction takes 2 cycles with no writes; the reset aborts the addu, RFWrite never asserts, and the state is FETCH after release.
- Sequence sw, ori, subu -> DMWrite only in sw's MA; ori EXE shows EXTOp=00, ALUOp=010; subu WB shows GPRSel=00; instr_cnt=3 with the macro defined, 0 without.
